cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor 0 for the 5-stage MIPS core. Sits in the memory stage, directly downstream of the E/M pipeline register, and consumes its PC, branch-delay flag and exception code.
- Holds the SR, Cause, EPC and PRId registers and serves mtc0/mfc0.
- Arbitrates hardware interrupts against synchronous exceptions and raises the pipeline-wide flush/redirect request `req`. The E/M register uses `req` to load PC 0x4180 and clear its other fields.
- Produces the EPC value used by eret.

Parameters:
- PRID_VAL, 32'h2001_0700, read-only PRId contents.
- HANDLER_PC, 32'h0000_4180, exception entry address; exported for the PC mux.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- a1  in  5  CP0 register number read by mfc0 (rd field)
- a2  in  5  CP0 register number written by mtc0
- din  in  32  mtc0 write data (forwarded rt value in M)
- we  in  1  mtc0 in M stage
- pc_m  in  32  PC of the instruction currently in M (bubbles carry a valid PC)
- bd_m  in  1  M instruction is in a branch delay slot
- exc_code_m  in  5  pending exception code from earlier stages (0 = none)
- eret_m  in  1  eret in M stage
- hw_int  in  6  external interrupt lines, level-sensitive
- dout  out  32  mfc0 read data
- epc_out  out  32  EPC for eret redirect
- req  out  1  take interrupt/exception this cycle
- handler_pc  out  32  constant HANDLER_PC

Behaviour:
Register map (all other numbers read 0, writes ignored):
- 12 SR: IM[15:10], EXL[1], IE[0]. Other bits read 0.
- 13 Cause: BD[31], IP[15:10], ExcCode[6:2]. Software-read-only.
- 14 EPC: 32 bits.
- 15 PRId: PRID_VAL.

Reset:
- IM=0, EXL=0, IE=0, BD=0, IP=0, ExcCode=0, EPC=0.
- Consequently req=0 and dout=0 for a1≠15. PRId reads PRID_VAL.

Request logic (combinational, same cycle as inputs):
- int_req = |(hw_int & IM) & IE & ~EXL
- exc_req = (exc_code_m != 0) & ~EXL
- req = int_req | exc_req
- Interrupt has priority over exception.

On the clk edge with req=1 (and no reset):
- EXL <= 1
- ExcCode <= int_req ? 0 : exc_code_m
- BD <= bd_m
- EPC <= bd_m ? pc_m - 4 : pc_m, using 32-bit wrap arithmetic
- Any concurrent mtc0 and eret are suppressed.

IP update:
- IP <= hw_int every cycle, independent of req, EXL and IM.

mtc0 (we=1, req=0):
- a2=12 writes IM, EXL and IE from din[15:10], din[1] and din[0].
- a2=14 writes EPC <= din.
- Writes to 13 and 15 are ignored.

eret_m=1, req=0:
- EXL <= 0 on the edge.
- If we is also asserted with a2=12 in the same cycle, eret wins for EXL; the IM and IE writes still apply.

mfc0:
- dout = register[a1], combinational, pre-edge value. There is no write-to-read bypass inside the block.

EPC forwarding:
- epc_out = (we && a2==14 && !req) ? din : EPC.
- This covers mtc0 EPC immediately followed by eret.

Boundary conditions:
- Nested exceptions are masked while EXL=1. exc_code_m is then ignored and the pipeline's bubble handling takes over.
- Reset has priority over every other event.
- hw_int is sampled continuously with no latching: an interrupt withdrawn before it is taken is lost.

Decomposition:
- Shared package cp0_pkg:
  - register numbers CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15
  - field bit positions
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12
- No sub-module. A single always block per register group plus combinational request/read logic; roughly 150 lines.

Test Plan:
1. Reset, then mtc0 SR din=32'h0000_0401 with hw_int=6'b000001 → next cycle req=1; edge gives EXL=1, ExcCode=0, EPC=pc_m (e.g. 32'h3010), and mfc0 Cause reads 32'h0000_0400.
2. exc_code_m=12, bd_m=1, pc_m=32'h3024, IE=0 → req=1 (exceptions ignore IE); EPC=32'h3020, Cause=32'h8000_0030.
3. EXL=1, exc_code_m=4, hw_int=6'h3F → req=0; EPC and ExcCode are unchanged.
4. Interrupt and exception together (IM=6'h3F, IE=1, hw_int=6'h02, exc_code_m=10) → ExcCode=0 (interrupt wins).
5. mtc0 EPC din=32'h3100 with eret_m=1 in the same cycle → epc_out=32'h3100 that cycle; EPC=32'h3100 and EXL=0 after the edge.
6. mtc0 Cause din=32'hFFFF_FFFF, then mfc0 PRId → Cause unchanged; dout=PRID_VAL.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor 0 block: register numbers,
// field positions inside SR and Cause, exception codes and packing helpers.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int SR_IM_MSB     = 15;

    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_IP_MSB  = 15;
    localparam int CAUSE_BD_BIT  = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_t;

    // Assemble the architectural SR view; unimplemented bits read as zero.
    function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        logic [31:0] r;
        r = '0;
        r[SR_IM_MSB:SR_IM_LSB] = im;
        r[SR_EXL_BIT]          = exl;
        r[SR_IE_BIT]           = ie;
        return r;
    endfunction

    // Assemble the architectural Cause view; unimplemented bits read as zero.
    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] exc_code);
        logic [31:0] r;
        r = '0;
        r[CAUSE_BD_BIT]                = bd;
        r[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip;
        r[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code;
        return r;
    endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0 for the 5-stage MIPS core. Lives in the memory stage, holds
// SR/Cause/EPC/PRId, serves mtc0/mfc0, arbitrates interrupts against
// synchronous exceptions and raises the pipeline flush/redirect request.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h2001_0700,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [31:0] din,
    input  logic        we,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exc_code_m,
    input  logic        eret_m,
    input  logic [5:0]  hw_int,
    output logic [31:0] dout,
    output logic [31:0] epc_out,
    output logic        req,
    output logic [31:0] handler_pc
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        wr_sr;
    logic        wr_epc;

    // Request arbitration; EXL masks both sources so nested events are dropped.
    always_comb begin
        int_req = (|(hw_int & im)) & ie & ~exl;
        exc_req = (exc_code_m != 5'd0) & ~exl;
        req     = int_req | exc_req;
        wr_sr   = we & (a2 == CP0_SR) & ~req;
        wr_epc  = we & (a2 == CP0_EPC) & ~req;
    end

    // SR: exception entry sets EXL; otherwise mtc0 writes and eret clears EXL.
    always_ff @(posedge clk) begin
        if (reset) begin
            im  <= '0;
            exl <= 1'b0;
            ie  <= 1'b0;
        end else if (req) begin
            exl <= 1'b1;
        end else begin
            if (wr_sr) begin
                im  <= din[SR_IM_MSB:SR_IM_LSB];
                exl <= din[SR_EXL_BIT];
                ie  <= din[SR_IE_BIT];
            end
            if (eret_m) begin
                exl <= 1'b0;
            end
        end
    end

    // Cause: IP mirrors the interrupt lines every cycle; BD/ExcCode load on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
        end else begin
            ip <= hw_int;
            if (req) begin
                bd       <= bd_m;
                exc_code <= int_req ? EXC_INT : exc_code_m;
            end
        end
    end

    // EPC: restart address on entry (back up over the branch for delay slots), else mtc0.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc <= '0;
        end else if (req) begin
            epc <= bd_m ? (pc_m - 32'd4) : pc_m;
        end else if (wr_epc) begin
            epc <= din;
        end
    end

    // mfc0 read mux and the eret target with forwarding of an in-flight EPC write.
    always_comb begin
        dout = '0;
        case (a1)
            CP0_SR:    dout = pack_sr(im, exl, ie);
            CP0_CAUSE: dout = pack_cause(bd, ip, exc_code);
            CP0_EPC:   dout = epc;
            CP0_PRID:  dout = PRID_VAL;
            default:   dout = '0;
        endcase
        epc_out    = wr_epc ? din : epc;
        handler_pc = HANDLER_PC;
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit. Each scenario pushes its expected
// observations onto a scoreboard queue while driving stimulus, then pops
// and compares them as the DUT outputs become observable.
module tb_cp0_unit;
    import cp0_pkg::*;

    localparam logic [31:0] PRID = 32'h2001_0700;
    localparam logic [31:0] HPC  = 32'h0000_4180;

    logic        clk;
    logic        reset;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic        eret_m;
    logic [5:0]  hw_int;
    logic [31:0] dout;
    logic [31:0] epc_out;
    logic        req;
    logic [31:0] handler_pc;

    logic [31:0] sb[$];
    logic [31:0] got;
    logic [31:0] exp;
    int          total = 0;
    int          bad   = 0;

    cp0_unit dut (
        .clk        (clk),
        .reset      (reset),
        .a1         (a1),
        .a2         (a2),
        .din        (din),
        .we         (we),
        .pc_m       (pc_m),
        .bd_m       (bd_m),
        .exc_code_m (exc_code_m),
        .eret_m     (eret_m),
        .hw_int     (hw_int),
        .dout       (dout),
        .epc_out    (epc_out),
        .req        (req),
        .handler_pc (handler_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we         = 1'b0;
        a2         = 5'd0;
        din        = 32'h0;
        eret_m     = 1'b0;
        exc_code_m = 5'd0;
        bd_m       = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] num, output logic [31:0] val);
        a1 = num;
        #1;
        val = dout;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        hw_int = 6'h0;
        pc_m = 32'h3000;
        exc_code_m = EXC_OV;
        tick();
        tick();
        reset = 1'b0;
        exc_code_m = 5'd0;
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        sb.push_back(PRID);
        sb.push_back(HPC);
        #1;
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL reset_req actual=%h required=%h", got, exp); end
        read_reg(CP0_SR, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL reset_sr actual=%h required=%h", got, exp); end
        read_reg(CP0_CAUSE, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL reset_cause actual=%h required=%h", got, exp); end
        read_reg(CP0_EPC, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL reset_epc actual=%h required=%h", got, exp); end
        read_reg(CP0_PRID, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL reset_prid actual=%h required=%h", got, exp); end
        got = handler_pc; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL handler_pc actual=%h required=%h", got, exp); end
    endtask

    task automatic test_interrupt();
        idle();
        we = 1'b1; a2 = CP0_SR; din = 32'h0000_0401;
        hw_int = 6'b000001; pc_m = 32'h3000;
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        #1;
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL int_req_during_write actual=%h required=%h", got, exp); end
        read_reg(CP0_SR, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL int_sr_no_bypass actual=%h required=%h", got, exp); end
        tick();
        idle();
        pc_m = 32'h3010;
        sb.push_back(32'h1);
        #1;
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL int_req actual=%h required=%h", got, exp); end
        tick();
        idle();
        sb.push_back(32'h0000_0403);
        sb.push_back(32'h0000_0400);
        sb.push_back(32'h0000_3010);
        sb.push_back(32'h0);
        read_reg(CP0_SR, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL int_sr actual=%h required=%h", got, exp); end
        read_reg(CP0_CAUSE, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL int_cause actual=%h required=%h", got, exp); end
        read_reg(CP0_EPC, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL int_epc actual=%h required=%h", got, exp); end
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL int_req_masked_exl actual=%h required=%h", got, exp); end
    endtask

    task automatic test_exception();
        idle();
        we = 1'b1; a2 = CP0_SR; din = 32'h0; hw_int = 6'h0;
        tick();
        idle();
        exc_code_m = EXC_OV; bd_m = 1'b1; pc_m = 32'h3024;
        we = 1'b1; a2 = CP0_EPC; din = 32'hDEAD_BEEF;
        sb.push_back(32'h1);
        sb.push_back(32'h0000_3010);
        #1;
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL exc_req_ie0 actual=%h required=%h", got, exp); end
        got = epc_out; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL exc_epc_out_no_fwd actual=%h required=%h", got, exp); end
        tick();
        idle();
        sb.push_back(32'h8000_0030);
        sb.push_back(32'h0000_3020);
        sb.push_back(32'h0000_0002);
        read_reg(CP0_CAUSE, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL exc_cause actual=%h required=%h", got, exp); end
        read_reg(CP0_EPC, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL exc_epc actual=%h required=%h", got, exp); end
        read_reg(CP0_SR, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL exc_sr actual=%h required=%h", got, exp); end
    endtask

    task automatic test_nested();
        idle();
        we = 1'b1; a2 = CP0_SR; din = 32'h0000_FC03;
        tick();
        idle();
        exc_code_m = EXC_ADEL; hw_int = 6'h3F; pc_m = 32'h3050;
        sb.push_back(32'h0);
        #1;
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL nested_req actual=%h required=%h", got, exp); end
        tick();
        idle();
        sb.push_back(32'h8000_FC30);
        sb.push_back(32'h0000_3020);
        sb.push_back(32'h0000_FC03);
        read_reg(CP0_CAUSE, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL nested_cause actual=%h required=%h", got, exp); end
        read_reg(CP0_EPC, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL nested_epc actual=%h required=%h", got, exp); end
        read_reg(CP0_SR, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL nested_sr actual=%h required=%h", got, exp); end
    endtask

    task automatic test_priority();
        idle();
        we = 1'b1; a2 = CP0_SR; din = 32'h0000_FC01; hw_int = 6'h0;
        tick();
        idle();
        hw_int = 6'h02; exc_code_m = EXC_RI; pc_m = 32'h3040; bd_m = 1'b0;
        sb.push_back(32'h1);
        #1;
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL prio_req actual=%h required=%h", got, exp); end
        tick();
        idle();
        sb.push_back(32'h0000_0800);
        sb.push_back(32'h0000_3040);
        sb.push_back(32'h0000_FC03);
        read_reg(CP0_CAUSE, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL prio_cause actual=%h required=%h", got, exp); end
        read_reg(CP0_EPC, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL prio_epc actual=%h required=%h", got, exp); end
        read_reg(CP0_SR, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL prio_sr actual=%h required=%h", got, exp); end
    endtask

    task automatic test_eret_fwd();
        idle();
        hw_int = 6'h0;
        we = 1'b1; a2 = CP0_EPC; din = 32'h0000_3100; eret_m = 1'b1;
        sb.push_back(32'h0);
        sb.push_back(32'h0000_3100);
        #1;
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL eret_req actual=%h required=%h", got, exp); end
        got = epc_out; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL eret_epc_fwd actual=%h required=%h", got, exp); end
        tick();
        idle();
        sb.push_back(32'h0000_FC01);
        sb.push_back(32'h0000_3100);
        sb.push_back(32'h0000_3100);
        sb.push_back(32'h0);
        read_reg(CP0_SR, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL eret_sr actual=%h required=%h", got, exp); end
        read_reg(CP0_EPC, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL eret_epc actual=%h required=%h", got, exp); end
        got = epc_out; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL eret_epc_out actual=%h required=%h", got, exp); end
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL eret_req_after actual=%h required=%h", got, exp); end
    endtask

    task automatic test_eret_sr();
        idle();
        we = 1'b1; a2 = CP0_SR; din = 32'h0000_0002;
        tick();
        idle();
        we = 1'b1; a2 = CP0_SR; din = 32'h0000_0C03; eret_m = 1'b1;
        tick();
        idle();
        sb.push_back(32'h0000_0C01);
        read_reg(CP0_SR, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL eret_sr_same_cycle actual=%h required=%h", got, exp); end
    endtask

    task automatic test_read_only();
        idle();
        we = 1'b1; a2 = CP0_CAUSE; din = 32'hFFFF_FFFF;
        tick();
        idle();
        we = 1'b1; a2 = CP0_PRID; din = 32'hFFFF_FFFF;
        tick();
        idle();
        we = 1'b1; a2 = 5'd0; din = 32'hFFFF_FFFF;
        tick();
        idle();
        sb.push_back(32'h0);
        sb.push_back(PRID);
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        sb.push_back(32'h0000_3100);
        sb.push_back(32'h0000_0C01);
        read_reg(CP0_CAUSE, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL ro_cause actual=%h required=%h", got, exp); end
        read_reg(CP0_PRID, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL ro_prid actual=%h required=%h", got, exp); end
        read_reg(5'd0, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL ro_reg0 actual=%h required=%h", got, exp); end
        read_reg(5'd31, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL ro_reg31 actual=%h required=%h", got, exp); end
        read_reg(CP0_EPC, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL ro_epc actual=%h required=%h", got, exp); end
        read_reg(CP0_SR, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL ro_sr actual=%h required=%h", got, exp); end
    endtask

    task automatic test_wrap();
        idle();
        exc_code_m = EXC_ADES; bd_m = 1'b1; pc_m = 32'h0000_0002;
        sb.push_back(32'h1);
        #1;
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL wrap_req actual=%h required=%h", got, exp); end
        tick();
        idle();
        sb.push_back(32'hFFFF_FFFE);
        sb.push_back(32'h8000_0014);
        read_reg(CP0_EPC, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL wrap_epc actual=%h required=%h", got, exp); end
        read_reg(CP0_CAUSE, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL wrap_cause actual=%h required=%h", got, exp); end
    endtask

    task automatic test_back_to_back();
        idle();
        hw_int = 6'h01;
        sb.push_back(32'h0);
        #1;
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL lost_req_exl actual=%h required=%h", got, exp); end
        tick();
        idle();
        hw_int = 6'h0; eret_m = 1'b1;
        tick();
        idle();
        sb.push_back(32'h0);
        sb.push_back(32'h0000_0C01);
        sb.push_back(32'h8000_0014);
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL lost_req_after actual=%h required=%h", got, exp); end
        read_reg(CP0_SR, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL lost_sr actual=%h required=%h", got, exp); end
        read_reg(CP0_CAUSE, got); exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL lost_cause actual=%h required=%h", got, exp); end
        hw_int = 6'h02;
        sb.push_back(32'h1);
        #1;
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL im_enabled_req actual=%h required=%h", got, exp); end
        hw_int = 6'h04;
        sb.push_back(32'h0);
        #1;
        got = {31'b0, req}; exp = sb.pop_front(); total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL im_masked_req actual=%h required=%h", got, exp); end
        hw_int = 6'h0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        a1 = 5'd0;
        hw_int = 6'h0;
        pc_m = 32'h0;
        idle();
        test_reset();
        test_interrupt();
        test_exception();
        test_nested();
        test_priority();
        test_eret_fwd();
        test_eret_sr();
        test_read_only();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
